// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq
//   Sequential modular reducer. Takes a signed 8-bit value Din and a signed
//   5-bit modulus Q over a valid/ready handshake. It returns the canonical
//   residue Dout in 0..Q-1 and the signed quotient Quot, so that
//   Din = Quot*Q + Dout. The value is corrected by one add or subtract of Q
//   per clock. A modulus outside 2..15 returns Err=1 with a zero result.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   Din        signed value to reduce (-128..127)
//   Q          signed modulus (legal 2..15)
//   in_valid   Din/Q valid
//   in_ready   block can accept a new transaction (IDLE only)
//   Dout       residue 0..Q-1
//   Quot       signed quotient
//   Err        modulus was illegal for this transaction
//   out_valid  Dout/Quot/Err valid
//   out_ready  consumer accepts the result
module mod_reduce_seq (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] Din,
  input  logic signed [4:0] Q,
  input  logic              in_valid,
  output logic              in_ready,
  output logic        [3:0] Dout,
  output logic signed [7:0] Quot,
  output logic              Err,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_n;

  // Working registers. These carry data only, so they are not reset; a
  // transaction always reloads them on acceptance.
  logic signed [8:0] acc, acc_n;
  logic signed [4:0] q_reg, q_reg_n;
  logic signed [7:0] quot, quot_n;

  // Registered outputs.
  logic        [3:0] dout_n;
  logic signed [7:0] quot_out_n;
  logic              err_n;
  logic              out_valid_n;
  logic              in_ready_n;

  // Widen the 8-bit input to the 9-bit accumulator so that adding or
  // subtracting a 4-bit modulus can never wrap.
  function automatic logic signed [8:0] sext_din(input logic signed [7:0] v);
    return {v[7], v};
  endfunction

  function automatic logic signed [8:0] sext_q(input logic signed [4:0] v);
    return {{4{v[4]}}, v};
  endfunction

  function automatic logic q_legal(input logic signed [4:0] v);
    return (v >= 5'sd2) && (v <= 5'sd15);
  endfunction

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    q_reg_n     = q_reg;
    quot_n      = quot;
    dout_n      = Dout;
    quot_out_n  = Quot;
    err_n       = Err;
    out_valid_n = out_valid;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          acc_n   = sext_din(Din);
          q_reg_n = Q;
          quot_n  = 8'sd0;
          state_n = LOAD;
        end
      end
      // One settle cycle after acceptance: the first check always works on
      // operands that have been sitting in registers for a full cycle.
      LOAD: begin
        state_n = RUN;
      end
      RUN: begin
        if (!q_legal(q_reg)) begin
          err_n       = 1'b1;
          dout_n      = 4'd0;
          quot_out_n  = 8'sd0;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end else if (acc < 9'sd0) begin
          acc_n  = acc + sext_q(q_reg);
          quot_n = quot - 8'sd1;
        end else if (acc >= sext_q(q_reg)) begin
          acc_n  = acc - sext_q(q_reg);
          quot_n = quot + 8'sd1;
        end else begin
          // acc is now in 0..Q-1 with Q <= 15, so the low nibble is exact.
          dout_n      = acc[3:0];
          quot_out_n  = quot;
          err_n       = 1'b0;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // in_ready is registered from the next state so it is high exactly while
    // the block sits in IDLE and never overlaps a pending result.
    in_ready_n = (state_n == IDLE);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Dout      <= 4'd0;
      Quot      <= 8'sd0;
      Err       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state     <= state_n;
      Dout      <= dout_n;
      Quot      <= quot_out_n;
      Err       <= err_n;
      out_valid <= out_valid_n;
      in_ready  <= in_ready_n;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    acc   <= acc_n;
    q_reg <= q_reg_n;
    quot  <= quot_n;
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
module tb_mod_reduce_seq;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] Din;
  logic signed [4:0] Q;
  logic              in_valid;
  logic              in_ready;
  logic        [3:0] Dout;
  logic signed [7:0] Quot;
  logic              Err;
  logic              out_valid;
  logic              out_ready;

  mod_reduce_seq dut (
    .clk       (clk),
    .rst       (rst),
    .Din       (Din),
    .Q         (Q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Dout      (Dout),
    .Quot      (Quot),
    .Err       (Err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        [3:0] dout;
    logic signed [7:0] quot;
    logic              err;
    int                lat;
    int                e0;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, so inputs driven
  // on that falling edge are already visible.
  bit ov_prev = 1'b0;
  bit hs_prev = 1'b0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("in_ready_after_handshake", int'(in_ready), 1);
      if (out_valid) begin
        chk("in_ready_low_while_valid", int'(in_ready), 0);
        if (sb.size() == 0) begin
          if (!ov_prev) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got Dout=%0d Quot=%0d Err=%0d expected no result",
                     Dout, Quot, Err);
          end
        end else begin
          if (!ov_prev) chk("latency", edge_n - sb[0].e0, sb[0].lat);
          chk("dout", int'(Dout), int'(sb[0].dout));
          chk("quot", int'(Quot), int'(sb[0].quot));
          chk("err", int'(Err), int'(sb[0].err));
          if (out_ready) void'(sb.pop_front());
        end
      end
      hs_prev = out_valid && out_ready;
      ov_prev = out_valid && !out_ready;
    end
  end

  task automatic send(input logic signed [7:0] din, input logic signed [4:0] q,
                      input logic [3:0] edout, input logic signed [7:0] equot,
                      input logic eerr, input int lat);
    exp_t e;
    int   t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end else begin
      Din      = din;
      Q        = q;
      in_valid = 1'b1;
      e.dout   = edout;
      e.quot   = equot;
      e.err    = eerr;
      e.lat    = lat;
      e.e0     = edge_n + 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    Din       = 8'sd0;
    Q         = 5'sd0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_dout", int'(Dout), 0);
    chk("reset_quot", int'(Quot), 0);
    chk("reset_err", int'(Err), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", int'(in_ready), 1);

    // Basic reductions: Din, Q, Dout, Quot, Err, latency
    send(8'sd23,   5'sd7,  4'd2,  8'sd3,   1'b0, 5);
    send(-8'sd9,   5'sd5,  4'd1,  -8'sd2,  1'b0, 4);
    send(8'sd4,    5'sd5,  4'd4,  8'sd0,   1'b0, 2);
    send(-8'sd128, 5'sd2,  4'd0,  -8'sd64, 1'b0, 66);
    send(8'sd127,  5'sd15, 4'd7,  8'sd8,   1'b0, 10);
    send(-8'sd1,   5'sd15, 4'd14, -8'sd1,  1'b0, 3);

    // Illegal moduli, then a normal transaction
    send(8'sd50,   5'sd1,  4'd0,  8'sd0,   1'b1, 2);
    send(-8'sd7,   -5'sd3, 4'd0,  8'sd0,   1'b1, 2);
    send(8'sd10,   5'sd3,  4'd1,  8'sd3,   1'b0, 5);
    wait_empty();

    // Backpressure with ignored input pulses
    out_ready = 1'b0;
    send(8'sd20, 5'sd6, 4'd2, 8'sd3, 1'b0, 5);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("backpressure_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Din      = 8'sd55;
      Q        = 5'sd7;
      in_valid = (i % 2 == 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty();
    repeat (5) @(negedge clk);

    // Reset in the middle of a long reduction
    send(8'sd100, 5'sd3, 4'd1, 8'sd33, 1'b0, 35);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("midrst_dout", int'(Dout), 0);
    chk("midrst_quot", int'(Quot), 0);
    chk("midrst_err", int'(Err), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    send(8'sd8, 5'sd3, 4'd2, 8'sd2, 1'b0, 4);
    wait_empty();

    // Quiet tail: any spurious result is reported by the monitor
    repeat (40) @(negedge clk);
    chk("final_out_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
